// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - register map, flag positions, FSM states and frame record for the CAN TX sequencer
package can_pkg;

    localparam logic [1:0] RS_ID    = 2'd0;
    localparam logic [1:0] RS_DLCF  = 2'd1;
    localparam logic [1:0] RS_DATA0 = 2'd2;
    localparam logic [1:0] RS_DATA1 = 2'd3;

    localparam int F_ACK    = 11;
    localparam int F_BIT    = 10;
    localparam int F_LOST   = 9;
    localparam int F_RTS    = 8;
    localparam int F_STROBE = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ID,
        S_WR_D0,
        S_WR_D1,
        S_WR_DLC,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] id;
        logic [3:0]  dlc;
        logic [31:0] data0;
        logic [31:0] data1;
    } frame_t;

endpackage

// File: rtl/can_tx_sequencer_if.sv
// rtl/can_tx_sequencer_if.sv - frame push port and CAN peripheral register port
interface can_tx_sequencer_if;

    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_id;
    logic [3:0]  push_dlc;
    logic [31:0] push_data0;
    logic [31:0] push_data1;

    logic        can_cs;
    logic [1:0]  can_rs;
    logic [3:0]  can_bytesel;
    logic [31:0] can_d;
    logic [31:0] can_q;

    modport master (
        input  push_valid, push_id, push_dlc, push_data0, push_data1, can_q,
        output push_ready, can_cs, can_rs, can_bytesel, can_d
    );

    modport slave (
        output push_valid, push_id, push_dlc, push_data0, push_data1, can_q,
        input  push_ready, can_cs, can_rs, can_bytesel, can_d
    );

endinterface

// File: rtl/can_frame_fifo.sv
// rtl/can_frame_fifo.sv - DEPTH-entry frame queue with valid/ready push and pop strobe
module can_frame_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    output logic          push_ready,
    input  frame_t        push_frame,
    input  logic          pop,
    output frame_t        head,
    output logic [LW-1:0] level
);

    frame_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;

    // Ready follows the registered level, so a pop while full frees space only next cycle.
    assign push_ready = (level != LW'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(pop);
        end
    end

endmodule

// File: rtl/can_tx_sequencer.sv
// rtl/can_tx_sequencer.sv - loads queued frames into the CAN peripheral, strobes TX, polls and retries
module can_tx_sequencer
    import can_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int MAX_RETRY = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    can_tx_sequencer_if.master     bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   tx_done,
    output logic                   tx_ok,
    output logic                   tx_giveup
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] retry_q;
    logic       ack_q;
    logic       bit_q;
    logic       lost_q;
    logic       pop;
    logic       poll_end;
    frame_t     head;
    frame_t     push_frame;
    logic       unused_q;

    assign push_frame = '{id: bus.push_id, dlc: bus.push_dlc,
                          data0: bus.push_data0, data1: bus.push_data1};
    assign unused_q   = ^{bus.can_q[31:12], bus.can_q[7:0]};

    can_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.push_valid),
        .push_ready (bus.push_ready),
        .push_frame (push_frame),
        .pop        (pop),
        .head       (head),
        .level      (level)
    );

    assign poll_end  = (state_q == S_POLL) && !bus.can_q[F_RTS];
    assign busy      = (state_q != S_IDLE);
    assign tx_done   = (state_q == S_DONE);
    assign tx_ok     = tx_done && ack_q && !bit_q && !lost_q;
    assign tx_giveup = tx_done && lost_q;
    assign pop       = tx_done;

    always_comb begin
        state_d         = state_q;
        bus.can_cs      = 1'b0;
        bus.can_rs      = RS_ID;
        bus.can_bytesel = 4'b0000;
        bus.can_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (level != '0) state_d = S_WR_ID;
            end
            S_WR_ID: begin
                bus.can_cs      = 1'b1;
                bus.can_rs      = RS_ID;
                bus.can_bytesel = 4'b1111;
                bus.can_d       = head.id;
                state_d         = S_WR_D0;
            end
            S_WR_D0: begin
                bus.can_cs      = 1'b1;
                bus.can_rs      = RS_DATA0;
                bus.can_bytesel = 4'b1111;
                bus.can_d       = head.data0;
                state_d         = S_WR_D1;
            end
            S_WR_D1: begin
                bus.can_cs      = 1'b1;
                bus.can_rs      = RS_DATA1;
                bus.can_bytesel = 4'b1111;
                bus.can_d       = head.data1;
                state_d         = S_WR_DLC;
            end
            S_WR_DLC: begin
                // Upper lanes stay off so baud/irq enable in the same register are untouched.
                bus.can_cs      = 1'b1;
                bus.can_rs      = RS_DLCF;
                bus.can_bytesel = 4'b0011;
                bus.can_d       = {23'h0, 1'b1, 4'h0, head.dlc};
                state_d         = S_GAP;
            end
            S_GAP: begin
                state_d = S_POLL;
            end
            S_POLL: begin
                bus.can_cs = 1'b1;
                bus.can_rs = RS_DLCF;
                if (poll_end) begin
                    if (!bus.can_q[F_LOST] || retry_q == 3'(MAX_RETRY)) state_d = S_DONE;
                    else state_d = S_WR_ID;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            ack_q   <= 1'b0;
            bit_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (poll_end) begin
                ack_q  <= bus.can_q[F_ACK];
                bit_q  <= bus.can_q[F_BIT];
                lost_q <= bus.can_q[F_LOST];
                // Lost arbitration drains the TX shift registers, hence the full reload on retry.
                if (bus.can_q[F_LOST] && retry_q != 3'(MAX_RETRY)) retry_q <= retry_q + 3'd1;
            end
            if (state_q == S_DONE) retry_q <= '0;
        end
    end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// tb/tb_can_tx_sequencer.sv - directed vectors and corner sequences for can_tx_sequencer
module tb_can_tx_sequencer;
    import can_pkg::*;

    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busy;
    logic [LW-1:0] level;
    logic          tx_done;
    logic          tx_ok;
    logic          tx_giveup;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    can_tx_sequencer_if bus();

    can_tx_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .level     (level),
        .tx_done   (tx_done),
        .tx_ok     (tx_ok),
        .tx_giveup (tx_giveup)
    );

    int          hold_cycles = 20;
    int          lost_limit  = 0;
    logic        model_clr   = 1'b0;
    int          rts_cnt;
    int          attempts;
    int          wpos;
    int          order_err;
    logic [31:0] last_id_d;
    logic [31:0] last_dlc_d;
    logic [3:0]  last_dlc_be;
    logic        rs0_read = 1'b0;

    function automatic logic [1:0] order_rs(int p);
        case (p)
            0: return RS_ID;
            1: return RS_DATA0;
            2: return RS_DATA1;
            default: return RS_DLCF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (model_clr || !rst_n) begin
            rts_cnt   <= 0;
            attempts  <= 0;
            wpos      <= 0;
            order_err <= 0;
        end else begin
            if (rts_cnt > 0) rts_cnt <= rts_cnt - 1;
            if (bus.can_cs) begin
                if (bus.can_bytesel == 4'b0000) begin
                    if (bus.can_rs == RS_ID) rs0_read <= 1'b1;
                end else begin
                    if (bus.can_rs != order_rs(wpos)) order_err <= order_err + 1;
                    wpos <= (wpos + 1) % 4;
                    if (bus.can_rs == RS_ID) begin
                        last_id_d <= bus.can_d;
                        attempts  <= attempts + 1;
                    end
                    if (bus.can_rs == RS_DLCF) begin
                        last_dlc_d  <= bus.can_d;
                        last_dlc_be <= bus.can_bytesel;
                        if (bus.can_d[F_STROBE]) rts_cnt <= hold_cycles;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.can_q = '0;
        if (rts_cnt != 0) bus.can_q[F_RTS] = 1'b1;
        else if (attempts > 0) begin
            if (attempts <= lost_limit) bus.can_q[F_LOST] = 1'b1;
            else bus.can_q[F_ACK] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] id, input logic [3:0] dlc,
                              input logic [31:0] d0, input logic [31:0] d1);
        bus.push_valid = 1'b1;
        bus.push_id    = id;
        bus.push_dlc   = dlc;
        bus.push_data0 = d0;
        bus.push_data1 = d1;
        for (int i = 0; i < 200; i++) begin
            if (bus.push_ready) begin
                @(negedge clk);
                bus.push_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.push_valid = 1'b0;
        chk("push_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output logic got, output logic ok, output logic gu);
        got = 1'b0; ok = 1'b0; gu = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done) begin
                got = 1'b1; ok = tx_ok; gu = tx_giveup;
                return;
            end
        end
    endtask

    task automatic clear_model(input int lost);
        lost_limit = lost;
        model_clr  = 1'b1;
        @(negedge clk);
        model_clr  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] id;
        logic [3:0]  dlc;
        logic [31:0] d0;
        logic [31:0] d1;
        int          lost;
        logic [31:0] exp_id_d;
        logic [31:0] exp_dlc_d;
        int          exp_att;
        logic        exp_ok;
        logic        exp_gu;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic got, ok, gu;
        vecs[0] = '{32'h0000_0123, 4'h2, 32'h0000_BEEF, 32'h0, 0,   32'h0000_0123, 32'h0000_0102, 1, 1'b1, 1'b0};
        vecs[1] = '{32'hC1AB_CDEF, 4'h4, 32'h1122_3344, 32'h5566_7788, 0, 32'hC1AB_CDEF, 32'h0000_0104, 1, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_07FF, 4'h8, 32'hDEAD_0001, 32'hCAFE_0002, 3, 32'h0000_07FF, 32'h0000_0108, 4, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0456, 4'h1, 32'h0000_00AA, 32'h0,         100, 32'h0000_0456, 32'h0000_0101, 8, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0001, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h8000_0001, 32'h0000_010F, 1, 1'b1, 1'b0};

        bus.push_valid = 1'b0;
        bus.push_id    = '0;
        bus.push_dlc   = '0;
        bus.push_data0 = '0;
        bus.push_data1 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(bus.can_cs), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First access lands two cycles after the push edge.
        clear_model(0);
        bus.push_valid = 1'b1;
        bus.push_id    = 32'h0000_0055;
        bus.push_dlc   = 4'h1;
        @(negedge clk);
        bus.push_valid = 1'b0;
        chk("lat_cs_after_push", 32'(bus.can_cs), 32'd0);
        chk("lat_level", 32'(level), 32'd1);
        @(negedge clk);
        chk("lat_cs_wr_id", 32'(bus.can_cs), 32'd1);
        chk("lat_rs_wr_id", 32'(bus.can_rs), 32'(RS_ID));
        wait_done(got, ok, gu);
        chk("lat_done_seen", 32'(got), 32'd1);

        for (int v = 0; v < 5; v++) begin
            clear_model(vecs[v].lost);
            push_frame(vecs[v].id, vecs[v].dlc, vecs[v].d0, vecs[v].d1);
            wait_done(got, ok, gu);
            chk($sformatf("v%0d_done_seen", v), 32'(got), 32'd1);
            chk($sformatf("v%0d_id_d", v), last_id_d, vecs[v].exp_id_d);
            chk($sformatf("v%0d_dlc_d", v), last_dlc_d, vecs[v].exp_dlc_d);
            chk($sformatf("v%0d_dlc_be", v), 32'(last_dlc_be), 32'h3);
            chk($sformatf("v%0d_attempts", v), 32'(attempts), 32'(vecs[v].exp_att));
            chk($sformatf("v%0d_tx_ok", v), 32'(ok), 32'(vecs[v].exp_ok));
            chk($sformatf("v%0d_tx_giveup", v), 32'(gu), 32'(vecs[v].exp_gu));
            chk($sformatf("v%0d_order", v), 32'(order_err), 32'd0);
            @(negedge clk);
        end

        // Fill to DEPTH, hold a third frame until the head frame is popped.
        clear_model(0);
        push_frame(32'h0000_000A, 4'h1, 32'h0, 32'h0);
        push_frame(32'h0000_000B, 4'h1, 32'h0, 32'h0);
        chk("full_level", 32'(level), 32'd2);
        chk("full_ready", 32'(bus.push_ready), 32'd0);
        bus.push_valid = 1'b1;
        bus.push_id    = 32'h0000_000C;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (tx_done) got = 1'b1;
        end
        chk("fill_done_a_seen", 32'(got), 32'd1);
        chk("fill_ready_at_pop", 32'(bus.push_ready), 32'd0);
        chk("fill_first_id", last_id_d, 32'h0000_000A);
        @(negedge clk);
        chk("fill_ready_after_pop", 32'(bus.push_ready), 32'd1);
        chk("fill_level_after_pop", 32'(level), 32'd1);
        @(negedge clk);
        bus.push_valid = 1'b0;
        chk("fill_level_refill", 32'(level), 32'd2);
        wait_done(got, ok, gu);
        chk("fill_second_id", last_id_d, 32'h0000_000B);
        wait_done(got, ok, gu);
        chk("fill_third_id", last_id_d, 32'h0000_000C);
        chk("fill_third_ok", 32'(ok), 32'd1);

        // Asynchronous reset while polling.
        clear_model(0);
        push_frame(32'h0000_0077, 4'h2, 32'h0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.can_cs && bus.can_rs == RS_DLCF && bus.can_bytesel == 4'b0000) got = 1'b1;
        end
        chk("poll_reached", 32'(got), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cs", 32'(bus.can_cs), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(bus.push_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", 32'(busy), 32'd0);

        chk("no_rs0_read", 32'(rs0_read), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
